// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: prescaled ms/sec/min stopwatch with IDLE/RUN/PAUSE control, sticky overflow, optional lap capture (STOPWATCH_LAP_EN)
module stopwatch_lap_timer #(
  parameter int TICK_DIV = 1000,
  parameter int MS_MAX = 999,
  parameter int SEC_MAX = 59,
  parameter int MIN_W = 8,
  localparam int MS_W = $clog2(MS_MAX + 1),
  localparam int SEC_W = $clog2(SEC_MAX + 1),
  localparam int PRE_W = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  output logic             running,
  output logic             paused,
  output logic [MS_W-1:0]  ms_count,
  output logic [SEC_W-1:0] sec_count,
  output logic [MIN_W-1:0] min_count,
  output logic             overflow,
  output logic             lap_valid,
  output logic [MS_W-1:0]  lap_ms,
  output logic [SEC_W-1:0] lap_sec,
  output logic [MIN_W-1:0] lap_min
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  logic [1:0] state, nxt;
  logic [PRE_W-1:0] pre;
  logic tick, ms_end, sec_end, min_end;
  assign running = state == RUN;
  assign paused = state == PAUSE;
  assign tick = running && pre == PRE_W'(TICK_DIV - 1);
  assign ms_end = ms_count == MS_W'(MS_MAX);
  assign sec_end = sec_count == SEC_W'(SEC_MAX);
  assign min_end = &min_count;
  // next state: clear beats stop beats start
  always_comb begin
    nxt = clear ? IDLE : stop ? (state == RUN ? PAUSE : state) : start ? RUN : state;
  end
  // control state plus prescaler and carry cascade; PAUSE holds everything
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nxt;
    if (reset || clear) begin
      pre <= '0;
      ms_count <= '0;
      sec_count <= '0;
      min_count <= '0;
      overflow <= 1'b0;
    end else if (running) begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick) begin
        ms_count <= ms_end ? '0 : ms_count + MS_W'(1);
        if (ms_end) sec_count <= sec_end ? '0 : sec_count + SEC_W'(1);
        if (ms_end && sec_end) min_count <= min_count + MIN_W'(1);
        if (ms_end && sec_end && min_end) overflow <= 1'b1;
      end
    end
  end
`ifdef STOPWATCH_LAP_EN
  // lap capture of the pre-edge time while RUN or PAUSE
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lap_valid <= 1'b0;
      lap_ms <= '0;
      lap_sec <= '0;
      lap_min <= '0;
    end else begin
      lap_valid <= lap && state != IDLE;
      if (lap && state != IDLE) begin
        lap_ms <= ms_count;
        lap_sec <= sec_count;
        lap_min <= min_count;
      end
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_valid = 1'b0;
  assign lap_ms = '0;
  assign lap_sec = '0;
  assign lap_min = '0;
`endif
endmodule
